// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) datapath (mult and gf_reduce).
package gf_pkg;

    // Largest field degree the shared helpers are sized for.
    localparam int GF_MAX_WIDTH = 32;
    localparam int WIDTH_BITS   = $clog2(GF_MAX_WIDTH) + 1;

    // Width of the mask helper result; covers a 2*64-bit product.
    localparam int MASK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } gf_state_e;

    // Low min(n, w) bits set; callers cast the result down to their width.
    function automatic logic [MASK_W-1:0] mask(input int w, input int n);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int k = 0; k < MASK_W; k++) begin
            if (k < n && k < w) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gf_reduce_step.sv
// One bit of polynomial long division: if bit i of r is set, cancel it by
// XORing in the full modulus P(x) = x^w + poly aligned so its top term hits i.
module gf_reduce_step
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int WB = $clog2(DATA_WIDTH) + 1,
    localparam int IB = WB + 1,
    localparam int PW = 2 * DATA_WIDTH,
    localparam int LB = $clog2(PW)
) (
    input  logic [PW-1:0]         r,
    input  logic [DATA_WIDTH-1:0] poly,
    input  logic [WB-1:0]         w,
    input  logic [IB-1:0]         i,
    output logic [PW-1:0]         r_next
);

    logic [PW-1:0] full_poly;
    logic [IB-1:0] shift;

    // Conditional subtract of the aligned modulus; out-of-range i leaves r alone.
    always_comb begin
        full_poly = PW'(poly) | (PW'(1) << w);
        shift     = i - {1'b0, w};
        r_next    = r;
        if (i >= {1'b0, w} && int'(i) < PW && r[i[LB-1:0]]) begin
            r_next = r ^ (full_poly << shift);
        end
    end

endmodule

// File: rtl/gf_reduce.sv
// Bit-serial GF(2^m) reduction: one product bit per cycle, top bit first.
// Handshake: op_enable is a held level request; op_finish rises with the
// result and stays high until op_enable drops, at which edge it clears.
module gf_reduce
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int WB = $clog2(DATA_WIDTH) + 1,
    localparam int IB = WB + 1,
    localparam int PW = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_enable,
    input  logic [WB-1:0]         in_width,
    input  logic [DATA_WIDTH-1:0] in_poly,
    input  logic [PW-1:0]         in_product,
    output logic [DATA_WIDTH-1:0] out_reduce_result,
    output logic                  op_finish
);

    // state_q is the FSM observation point for bound checkers.
    gf_state_e             state_q, state_d;
    logic [PW-1:0]         r_q, r_d, r_step;
    logic [DATA_WIDTH-1:0] poly_q, poly_d;
    logic [WB-1:0]         w_q, w_d;
    logic [IB-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  finish_q, finish_d;
    logic                  width_ok;

    gf_reduce_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .r      (r_q),
        .poly   (poly_q),
        .w      (w_q),
        .i      (idx_q),
        .r_next (r_step)
    );

    assign width_ok          = (in_width >= WB'(2)) && (in_width <= WB'(DATA_WIDTH));
    assign out_reduce_result = result_q;
    assign op_finish         = finish_q;

    // Next-state and datapath update; everything holds unless a branch overrides.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        poly_d   = poly_q;
        w_d      = w_q;
        idx_d    = idx_q;
        result_d = result_q;
        finish_d = finish_q;
        case (state_q)
            IDLE: begin
                if (op_enable) begin
                    if (width_ok) begin
                        // Product degree is at most 2w-2; anything above is ignored.
                        r_d     = in_product & PW'(mask(PW, 2 * int'(in_width) - 1));
                        poly_d  = in_poly & DATA_WIDTH'(mask(DATA_WIDTH, int'(in_width)));
                        w_d     = in_width;
                        idx_d   = {in_width, 1'b0} - IB'(2);
                        state_d = REDUCE;
                    end else begin
                        result_d = '0;
                        finish_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            REDUCE: begin
                if (!op_enable) begin
                    state_d = IDLE;
                end else begin
                    r_d = r_step;
                    if (idx_q == {1'b0, w_q}) begin
                        result_d = r_step[DATA_WIDTH-1:0]
                                 & DATA_WIDTH'(mask(DATA_WIDTH, int'(w_q)));
                        finish_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q - IB'(1);
                    end
                end
            end
            DONE: begin
                if (!op_enable) begin
                    finish_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Working register, index and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q      <= '0;
            poly_q   <= '0;
            w_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            poly_q   <= poly_d;
            w_q      <= w_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            finish_q <= finish_d;
        end
    end

endmodule
